// File: rtl/tl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tl_pkg : TileLink-UL opcode constants, field widths and slave FSM state type
// Revision: 1.0
// ---------------------------------------------------------------------------
package tl_pkg;

  localparam int OPCODE_W = 3;
  localparam int PARAM_W  = 3;
  localparam int SIZE_W   = 3;
  localparam int SINK_W   = 1;

  localparam logic [OPCODE_W-1:0] A_PUT_FULL        = 3'd0;
  localparam logic [OPCODE_W-1:0] A_PUT_PARTIAL     = 3'd1;
  localparam logic [OPCODE_W-1:0] A_GET             = 3'd4;
  localparam logic [OPCODE_W-1:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [OPCODE_W-1:0] D_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Low address bits that must be zero for a transfer of 2^size bytes.
  function automatic logic [2:0] align_mask(input logic [SIZE_W-1:0] size);
    case (size)
      3'd0:    align_mask = 3'b000;
      3'd1:    align_mask = 3'b001;
      3'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_byte_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tl_byte_ram : word-addressed storage, byte-enabled synchronous write,
//               combinational read. Contents are never reset.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tl_byte_ram #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [DATA_WIDTH/8-1:0]        be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic [DATA_WIDTH-1:0]          rdata
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/tl_ul_mem_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tl_ul_mem_slave : single-outstanding TileLink-UL memory slave with a fixed
//                   accept-to-response latency and request error checking.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tl_ul_mem_slave
  import tl_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    SRC_WIDTH   = 2,
  parameter int                    DEPTH_WORDS = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    LATENCY     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_W-1:0]     a_opcode,
  input  logic [PARAM_W-1:0]      a_param,
  input  logic [SIZE_W-1:0]       a_size,
  input  logic [SRC_WIDTH-1:0]    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [DATA_WIDTH/8-1:0] a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_W-1:0]     d_opcode,
  output logic [PARAM_W-1:0]      d_param,
  output logic [SIZE_W-1:0]       d_size,
  output logic [SRC_WIDTH-1:0]    d_source,
  output logic [SINK_W-1:0]       d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);
  localparam int IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH_WORDS * BYTES);

  state_e                  state, next_state;
  logic [3:0]              cnt;
  logic                    accept, req_err, is_get, is_put, in_range, misaligned;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [IDX_W-1:0]        word_idx;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic                    ram_we;
  logic                    unused_param;

  assign unused_param = ^a_param;

  // a_ready is held low for the whole time reset is asserted.
  assign a_ready = (state == ST_IDLE) && !reset;
  assign accept  = a_valid && a_ready;

  assign offset     = a_address - BASE_ADDR;
  assign in_range   = (a_address >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
  assign is_put     = (a_opcode == A_PUT_FULL) || (a_opcode == A_PUT_PARTIAL);
  assign is_get     = (a_opcode == A_GET);
  assign misaligned = |(a_address[2:0] & align_mask(a_size));
  assign req_err    = !in_range || !(is_put || is_get) ||
                      (a_size > SIZE_W'(BYTE_SHIFT)) || misaligned;
  assign word_idx   = offset[BYTE_SHIFT +: IDX_W];
  assign ram_we     = accept && !req_err && is_put;

  tl_byte_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (a_mask),
    .addr  (word_idx),
    .wdata (a_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept)     next_state = ST_WAIT;
      ST_WAIT: if (cnt == 4'd0) next_state = ST_RESP;
      ST_RESP: if (d_ready)    next_state = ST_IDLE;
      default:                 next_state = ST_IDLE;
    endcase
  end

  // Response fields are captured at accept and held untouched until the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 4'd0;
      d_opcode <= '0;
      d_size   <= '0;
      d_source <= '0;
      d_data   <= '0;
      d_error  <= 1'b0;
    end else if (accept) begin
      cnt      <= 4'(LATENCY - 1);
      d_opcode <= is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
      d_size   <= a_size;
      d_source <= a_source;
      d_data   <= (is_get && !req_err) ? ram_rdata : '0;
      d_error  <= req_err;
    end else if (state == ST_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign d_valid = (state == ST_RESP);
  assign d_param = '0;
  assign d_sink  = '0;

endmodule
`default_nettype wire

// File: tb/tb_tl_ul_mem_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tl_ul_mem_slave : directed vectors with hand-computed expectations
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_tl_ul_mem_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [1:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_param, d_size;
  logic [1:0]  d_source;
  logic [0:0]  d_sink;
  logic [31:0] d_data;
  logic        d_error;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tl_ul_mem_slave #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .SRC_WIDTH   (2),
    .DEPTH_WORDS (256),
    .BASE_ADDR   (32'h0),
    .LATENCY     (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_param   (a_param),
    .a_size    (a_size),
    .a_source  (a_source),
    .a_address (a_address),
    .a_mask    (a_mask),
    .a_data    (a_data),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_opcode  (d_opcode),
    .d_param   (d_param),
    .d_size    (d_size),
    .d_source  (d_source),
    .d_sink    (d_sink),
    .d_data    (d_data),
    .d_error   (d_error)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [2:0] size, input logic [1:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    a_valid   = 1'b1;
    a_opcode  = op;
    a_size    = size;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
  endtask

  // Waits for d_valid after an accept edge; returns cycles elapsed (capped at 20).
  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!d_valid && lat < 20);
  endtask

  // Called #1 after a rising edge with the slave idle.
  task automatic do_txn(input string tag, input logic [2:0] op, input logic [2:0] size,
                        input logic [1:0] src, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic [2:0] exp_op, input logic exp_err,
                        input logic [31:0] exp_data);
    int lat;
    drive_a(op, size, src, addr, mask, data);
    check_val({tag, "_a_ready"}, 64'(a_ready), 64'd1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    wait_resp(lat);
    check_val({tag, "_latency"}, 64'(lat), 64'd2);
    check_val({tag, "_d_opcode"}, 64'(d_opcode), 64'(exp_op));
    check_val({tag, "_d_error"}, 64'(d_error), 64'(exp_err));
    check_val({tag, "_d_data"}, 64'(d_data), 64'(exp_data));
    check_val({tag, "_d_size_src"}, 64'({d_size, d_source}), 64'({size, src}));
    check_val({tag, "_param_sink"}, 64'({d_param, d_sink}), 64'd0);
    d_ready = 1'b1;
    @(posedge clk); #1;
    d_ready = 1'b0;
    check_val({tag, "_post_idle"}, 64'({d_valid, a_ready}), 64'b01);
  endtask

  initial begin
    int lat;
    reset = 1'b1; a_valid = 1'b0; d_ready = 1'b0; a_param = 3'd0;
    a_opcode = 3'd0; a_size = 3'd0; a_source = 2'd0; a_address = 32'd0;
    a_mask = 4'd0; a_data = 32'd0;

    #2;
    check_val("rst_a_ready", 64'(a_ready), 64'd0);
    check_val("rst_d_valid", 64'(d_valid), 64'd0);
    check_val("rst_d_fields", 64'({d_opcode, d_size, d_source, d_error}), 64'd0);
    check_val("rst_d_data", 64'(d_data), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_val("rel_a_ready", 64'(a_ready), 64'd1);
    @(posedge clk); #1;

    do_txn("put_full",  3'd0, 3'd2, 2'd1, 32'h10, 4'hF, 32'hDEADBEEF, 3'd0, 1'b0, 32'h0);
    do_txn("get_full",  3'd4, 3'd2, 2'd2, 32'h10, 4'hF, 32'h0,        3'd1, 1'b0, 32'hDEADBEEF);
    do_txn("put_part",  3'd1, 3'd2, 2'd0, 32'h10, 4'h1, 32'h000000AA, 3'd0, 1'b0, 32'h0);
    do_txn("get_part",  3'd4, 3'd2, 2'd3, 32'h10, 4'hF, 32'h0,        3'd1, 1'b0, 32'hDEADBEAA);
    do_txn("get_oob",   3'd4, 3'd2, 2'd1, 32'h400, 4'hF, 32'h0,       3'd1, 1'b1, 32'h0);
    do_txn("put_w0",    3'd0, 3'd2, 2'd0, 32'h0, 4'hF, 32'hCAFEF00D,  3'd0, 1'b0, 32'h0);
    do_txn("put_misal", 3'd0, 3'd2, 2'd2, 32'h2, 4'hF, 32'h11111111,  3'd0, 1'b1, 32'h0);
    do_txn("get_w0",    3'd4, 3'd2, 2'd0, 32'h0, 4'hF, 32'h0,         3'd1, 1'b0, 32'hCAFEF00D);
    do_txn("get_size3", 3'd4, 3'd3, 2'd1, 32'h10, 4'hF, 32'h0,        3'd1, 1'b1, 32'h0);
    do_txn("get_hmisal",3'd4, 3'd1, 2'd1, 32'h11, 4'hF, 32'h0,        3'd1, 1'b1, 32'h0);
    do_txn("bad_opc",   3'd2, 3'd2, 2'd1, 32'h10, 4'hF, 32'h0,        3'd0, 1'b1, 32'h0);
    do_txn("put_last",  3'd0, 3'd2, 2'd2, 32'h3FC, 4'hF, 32'h0BADCAFE, 3'd0, 1'b0, 32'h0);
    do_txn("get_last",  3'd4, 3'd2, 2'd2, 32'h3FC, 4'hF, 32'h0,       3'd1, 1'b0, 32'h0BADCAFE);
    do_txn("get_byte",  3'd4, 3'd0, 2'd3, 32'h13, 4'h8, 32'h0,        3'd1, 1'b0, 32'hDEADBEAA);

    // Back-pressure: response held while a second request waits on Channel A.
    drive_a(3'd4, 3'd2, 2'd1, 32'h10, 4'hF, 32'h0);
    @(posedge clk); #1;
    drive_a(3'd0, 3'd2, 2'd2, 32'h10, 4'hF, 32'h5555AAAA);
    wait_resp(lat);
    check_val("bp_latency", 64'(lat), 64'd2);
    for (int i = 0; i < 5; i++) begin
      check_val("bp_hold", 64'({d_valid, a_ready, d_opcode, d_error, d_source, d_data}),
                64'({1'b1, 1'b0, 3'd1, 1'b0, 2'd1, 32'hDEADBEAA}));
      @(posedge clk); #1;
    end
    d_ready = 1'b1;
    @(posedge clk); #1;
    d_ready = 1'b0;
    check_val("bp_release", 64'({d_valid, a_ready}), 64'b01);
    @(posedge clk); #1;
    a_valid = 1'b0;
    check_val("bp_second_acc", 64'(a_ready), 64'd0);
    wait_resp(lat);
    check_val("bp2_latency", 64'(lat), 64'd2);
    check_val("bp2_resp", 64'({d_opcode, d_error, d_source}), 64'({3'd0, 1'b0, 2'd2}));
    d_ready = 1'b1;
    @(posedge clk); #1;
    d_ready = 1'b0;

    // Reset during WAIT of a Get from source 3.
    drive_a(3'd4, 3'd2, 2'd3, 32'h10, 4'hF, 32'h0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_val("midrst_outs", 64'({d_valid, a_ready, d_source, d_opcode}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("midrst_hold", 64'({d_valid, a_ready}), 64'd0);
    end
    reset = 1'b0;
    #1;
    check_val("midrst_rel_ready", 64'(a_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_val("midrst_no_dvalid", 64'(d_valid), 64'd0);
    end
    do_txn("get_after_rst", 3'd4, 3'd2, 2'd0, 32'h10, 4'hF, 32'h0, 3'd1, 1'b0, 32'h5555AAAA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tl_ul_mem_slave.md
TL_UL_MEM_SLAVE -- requirements
Module: tl_ul_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of a_address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data bus width; 32 or 64 only.
REQ-003 SHALL have parameter SRC_WIDTH, default 2, width of a_source/d_source.
REQ-004 SHALL have parameter DEPTH_WORDS, default 256, number of DATA_WIDTH words of storage; power of two.
REQ-005 SHALL have parameter BASE_ADDR, default 0, byte address of word 0; aligned to DEPTH_WORDS*DATA_WIDTH/8.
REQ-006 SHALL have parameter LATENCY, default 2, accept-to-d_valid cycles; range 1..15.
REQ-007 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-008 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-009 SHALL have port a_valid  in  1  Channel A request valid.
REQ-010 SHALL have port a_ready  out  1  Channel A accept.
REQ-011 SHALL have port a_opcode  in  3  0 PutFullData, 1 PutPartialData, 4 Get.
REQ-012 SHALL have port a_param  in  3  ignored; must be 0.
REQ-013 SHALL have port a_size  in  3  log2 bytes of the transfer.
REQ-014 SHALL have port a_source  in  SRC_WIDTH  requester ID.
REQ-015 SHALL have port a_address  in  ADDR_WIDTH  byte address.
REQ-016 SHALL have port a_mask  in  DATA_WIDTH/8  byte-lane enables.
REQ-017 SHALL have port a_data  in  DATA_WIDTH  write data.
REQ-018 SHALL have port d_valid  out  1  Channel D response valid.
REQ-019 SHALL have port d_ready  in  1  Channel D response accept.
REQ-020 SHALL have port d_opcode  out  3  0 AccessAck, 1 AccessAckData.
REQ-021 SHALL have port d_param  out  3  constant 0.
REQ-022 SHALL have port d_size  out  3  echo of captured a_size.
REQ-023 SHALL have port d_source  out  SRC_WIDTH  echo of captured a_source.
REQ-024 SHALL have port d_sink  out  1  constant 0.
REQ-025 SHALL have port d_data  out  DATA_WIDTH  read data; 0 for AccessAck or error.
REQ-026 SHALL have port d_error  out  1  request rejected.

Function
REQ-027 SHALL implement FSM IDLE->WAIT->RESP->IDLE with exactly one outstanding request.
REQ-028 SHALL drive a_ready=1 only in IDLE; accept = a_valid&&a_ready at a rising edge; IDLE->WAIT on accept.
REQ-029 SHALL on accept capture opcode, size, source, and compute error = address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*DATA_WIDTH/8) OR opcode not in {0,1,4} OR a_size>log2(DATA_WIDTH/8) OR address not aligned to 2^a_size.
REQ-030 SHALL index word (a_address-BASE_ADDR)>>log2(DATA_WIDTH/8), truncated to log2(DEPTH_WORDS) bits.
REQ-031 SHALL on accepted error-free Put write a_data byte lanes where a_mask=1 at the accept edge; error requests write nothing.
REQ-032 SHALL on accepted error-free Get capture the full word (post-reset contents) at the accept edge into the response data register.
REQ-033 SHALL load a 4-bit counter with LATENCY-1 on accept, decrement in WAIT, enter RESP when counter is 0; d_valid rises exactly LATENCY cycles after the accept edge.
REQ-034 SHALL hold d_valid and all d_* stable in RESP until d_valid&&d_ready; then go to IDLE; a_ready returns 1 the following cycle.
REQ-035 SHALL respond AccessAckData(1) to Get and AccessAck(0) to Put, errors included; d_data=0 unless error-free Get.
REQ-036 SHALL treat a_valid asserted during WAIT/RESP as back-pressured (no capture, no write).

Reset
REQ-037 SHALL on reset (any time, including mid-transaction) force IDLE, counter 0, a_ready=0 while asserted, d_valid=0, d_opcode/d_size/d_source/d_data/d_error=0; in-flight response is discarded; storage contents are not cleared.
REQ-038 SHALL assert a_ready=1 in the first cycle after reset deasserts.

Structure
REQ-039 SHALL take TL opcode constants (A: PUT_FULL=0, PUT_PARTIAL=1, GET=4; D: ACCESS_ACK=0, ACCESS_ACK_DATA=1) and OPCODE/PARAM/SIZE=3, SINK=1 widths from shared package tl_pkg.
REQ-040 SHALL instantiate storage as sub-module tl_byte_ram (synchronous write with byte enables, read in same cycle as request); FSM and checks in top.

Verification
REQ-041 SHALL cover PutFull addr 0x10 data 0xDEADBEEF mask 0xF, then Get 0x10 -> AccessAck, then AccessAckData d_data=0xDEADBEEF, d_error=0, each d_valid 2 cycles after accept.
REQ-042 SHALL cover PutPartial addr 0x10 data 0x000000AA mask 0x1 over 0xDEADBEEF, then Get -> 0xDEADBEAA.
REQ-043 SHALL cover Get addr 0x400 (DEPTH 256) -> AccessAckData d_error=1 d_data=0; Put addr 0x2 size 2 -> d_error=1, memory unchanged.
REQ-044 SHALL cover d_ready held 0 for 5 cycles -> d_valid and d_* stable, a_ready=0 throughout, second a_valid not accepted until cycle after d handshake.
REQ-045 SHALL cover reset asserted during WAIT of a Get with source 3 -> d_valid never rises, a_ready=1 one cycle after reset release.
